// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: moves a WIDTH-bit operand by up to STEP bits per clock,
// with valid/ready handshakes on both the request and the result side.
module seq_shifter #(
   parameter  int WIDTH = 32,
   parameter  int STEP  = 4,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic [SHW-1:0]   shift_amount,
   input  logic [2:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             err,
   output logic             busy
);

   localparam int           SW     = $clog2(STEP + 1);
   localparam logic [SHW:0] STEP_X = (SHW + 1)'(STEP);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
   typedef enum logic [2:0] {OP_SLL = 3'd0, OP_SRL, OP_SRA, OP_ROL, OP_ROR} op_e;

   state_e             state_q;
   op_e                op_q;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHW-1:0]     rem_q, rem_d;
   logic               sign_q;
   logic               in_ready_q, out_valid_q, err_q, busy_q;
   logic [WIDTH-1:0]   data_out_q;
   logic [SW-1:0]      step_amt;
   logic [2*WIDTH-1:0] dbl;

   // One step of at most STEP bits; the doubled vector serves rotates and the sign-filled SRA.
   always_comb begin
      dbl      = '0;
      work_d   = work_q;
      step_amt = ({1'b0, rem_q} >= STEP_X) ? SW'(STEP) : SW'(rem_q);
      rem_d    = rem_q - SHW'(step_amt);
      unique case (op_q)
         OP_SLL: work_d = work_q << step_amt;
         OP_SRL: work_d = work_q >> step_amt;
         OP_SRA: begin
            dbl    = {{WIDTH{sign_q}}, work_q} >> step_amt;
            work_d = dbl[WIDTH-1:0];
         end
         OP_ROL: begin
            dbl    = {work_q, work_q} << step_amt;
            work_d = dbl[2*WIDTH-1:WIDTH];
         end
         OP_ROR: begin
            dbl    = {work_q, work_q} >> step_amt;
            work_d = dbl[WIDTH-1:0];
         end
         default: work_d = work_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_SLL;
         work_q      <= '0;
         rem_q       <= '0;
         sign_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         data_out_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  work_q     <= data_in;
                  rem_q      <= shift_amount;
                  sign_q     <= data_in[WIDTH-1];
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (mode > 3'd4) begin
                     data_out_q  <= data_in;
                     err_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else if (shift_amount == '0) begin
                     data_out_q  <= data_in;
                     err_q       <= 1'b0;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     op_q    <= op_e'(mode);
                     state_q <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work_q <= work_d;
               rem_q  <= rem_d;
               if (rem_d == '0) begin
                  data_out_q  <= work_d;
                  err_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;
   assign err       = err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: default 32/4 instance with hand-computed vectors,
// plus 16/1 and 64/8 instances compared against single-cycle reference formulas.
module tb_seq_shifter;

   logic        clk = 1'b0;
   logic        rst_n;
   int          checks = 0;
   int          errors = 0;

   // default instance
   logic        in_valid, in_ready, out_valid, out_ready, err, busy;
   logic [31:0] data_in, data_out;
   logic [4:0]  shift_amount;
   logic [2:0]  mode;

   // WIDTH=16 STEP=1
   logic        a_iv, a_ir, a_ov, a_or, a_err, a_busy;
   logic [15:0] a_di, a_do;
   logic [3:0]  a_n;
   logic [2:0]  a_m;

   // WIDTH=64 STEP=8
   logic        b_iv, b_ir, b_ov, b_or, b_err, b_busy;
   logic [63:0] b_di, b_do;
   logic [5:0]  b_n;
   logic [2:0]  b_m;

   always #5 clk = ~clk;

   seq_shifter u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .shift_amount(shift_amount), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .err(err), .busy(busy)
   );

   seq_shifter #(.WIDTH(16), .STEP(1)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
      .data_in(a_di), .shift_amount(a_n), .mode(a_m),
      .out_valid(a_ov), .out_ready(a_or), .data_out(a_do),
      .err(a_err), .busy(a_busy)
   );

   seq_shifter #(.WIDTH(64), .STEP(8)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
      .data_in(b_di), .shift_amount(b_n), .mode(b_m),
      .out_valid(b_ov), .out_ready(b_or), .data_out(b_do),
      .err(b_err), .busy(b_busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_fn(input int w, input logic [63:0] d, input int n,
                                          input logic [2:0] m);
      logic [63:0] mask, x, r;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      x    = d & mask;
      case (m)
         3'd0:    r = (x << n) & mask;
         3'd1:    r = x >> n;
         3'd2: begin
            r = x >> n;
            if (x[w-1]) r = r | (mask & ~(mask >> n));
         end
         3'd3:    r = (n == 0) ? x : (((x << n) | (x >> (w - n))) & mask);
         3'd4:    r = (n == 0) ? x : (((x >> n) | (x << (w - n))) & mask);
         default: r = x;
      endcase
      return r;
   endfunction

   task automatic run_main(input string tag, input logic [31:0] d, input logic [4:0] n,
                           input logic [2:0] m, input logic [31:0] exp, input logic exp_err,
                           input int exp_lat);
      int lat;
      @(negedge clk);
      check({tag, " in_ready"}, in_ready, 1);
      in_valid = 1'b1; data_in = d; shift_amount = n; mode = m;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " data"}, data_out, exp);
      check({tag, " err"}, err, exp_err);
      @(posedge clk); #1;
      check({tag, " ov_drop"}, out_valid, 0);
      check({tag, " retain"}, data_out, exp);
   endtask

   task automatic run_p(input int w, input logic [63:0] d, input int n, input logic [2:0] m);
      int          lat, step, exp_lat;
      logic [63:0] exp, got;
      step    = (w == 16) ? 1 : 8;
      exp     = ref_fn(w, d, n, m);
      exp_lat = (m > 3'd4 || n == 0) ? 1 : (n + step - 1) / step + 1;
      @(negedge clk);
      if (w == 16) begin
         a_iv = 1'b1; a_di = d[15:0]; a_n = 4'(n); a_m = m;
      end else begin
         b_iv = 1'b1; b_di = d; b_n = 6'(n); b_m = m;
      end
      @(posedge clk); #1;
      a_iv = 1'b0; b_iv = 1'b0;
      lat = 1;
      while (!((w == 16) ? a_ov : b_ov) && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      got = (w == 16) ? {48'd0, a_do} : b_do;
      check($sformatf("w%0d m%0d n%0d data", w, m, n), got, exp);
      check($sformatf("w%0d m%0d n%0d latency", w, m, n), lat, exp_lat);
      check($sformatf("w%0d m%0d n%0d err", w, m, n), (w == 16) ? a_err : b_err, (m > 3'd4) ? 1 : 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int spurious;
      rst_n = 1'b0;
      in_valid = 1'b0; data_in = '0; shift_amount = '0; mode = '0; out_ready = 1'b1;
      a_iv = 1'b0; a_di = '0; a_n = '0; a_m = '0; a_or = 1'b1;
      b_iv = 1'b0; b_di = '0; b_n = '0; b_m = '0; b_or = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst in_ready", in_ready, 1);
      check("rst out_valid", out_valid, 0);
      check("rst data_out", data_out, 0);
      check("rst err", err, 0);
      check("rst busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_main("sll4",    32'hA5A5A5A5, 5'd4,  3'b000, 32'h5A5A5A50, 1'b0, 2);
      run_main("srl8",    32'hA5A5A5A5, 5'd8,  3'b001, 32'h00A5A5A5, 1'b0, 3);
      run_main("sra4",    32'hF0000000, 5'd4,  3'b010, 32'hFF000000, 1'b0, 2);
      run_main("sra8",    32'h7FFFFFFF, 5'd8,  3'b010, 32'h007FFFFF, 1'b0, 3);
      run_main("sra31",   32'h80000000, 5'd31, 3'b010, 32'hFFFFFFFF, 1'b0, 9);
      run_main("ror9",    32'h12345678, 5'd9,  3'b100, 32'h3C091A2B, 1'b0, 4);
      run_main("rol1",    32'h80000001, 5'd1,  3'b011, 32'h00000003, 1'b0, 2);
      run_main("zero",    32'hDEADBEEF, 5'd0,  3'b000, 32'hDEADBEEF, 1'b0, 1);
      run_main("illegal", 32'hDEADBEEF, 5'd5,  3'b111, 32'hDEADBEEF, 1'b1, 1);

      // backpressure with ignored requests and a simultaneous in_valid on the release edge
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; data_in = 32'hA5A5A5A5; shift_amount = 5'd4; mode = 3'b000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !out_valid; i++) begin
         @(posedge clk); #1;
      end
      check("bp out_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; data_in = 32'h11111111; shift_amount = 5'd2; mode = 3'b011;
         @(posedge clk); #1;
         check("bp hold valid", out_valid, 1);
         check("bp hold data", data_out, 32'h5A5A5A50);
         check("bp hold err", err, 0);
         check("bp in_ready", in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp release valid", out_valid, 0);
      check("bp release in_ready", in_ready, 1);
      check("bp no accept", busy, 0);
      check("bp retain", data_out, 32'h5A5A5A50);
      @(posedge clk); #1;
      check("bp idle busy", busy, 0);
      check("bp idle valid", out_valid, 0);

      // reset during the third SHIFT cycle aborts the operation
      @(negedge clk);
      in_valid = 1'b1; data_in = 32'hFFFFFFFF; shift_amount = 5'd31; mode = 3'b001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("abort started", busy, 1);
      repeat (2) @(posedge clk);
      #1;
      check("abort still shifting", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort in_ready", in_ready, 1);
      check("abort out_valid", out_valid, 0);
      check("abort data_out", data_out, 0);
      check("abort busy", busy, 0);
      check("abort err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) spurious++;
      end
      check("abort no result", spurious, 0);

      // parametrised instances against the reference formulas
      for (int m = 0; m < 5; m++) begin
         run_p(16, {32'd0, $urandom}, 1, 3'(m));
         run_p(16, {32'd0, $urandom}, 15, 3'(m));
         run_p(16, {32'd0, $urandom}, int'($urandom_range(2, 14)), 3'(m));
         run_p(64, {$urandom, $urandom}, 1, 3'(m));
         run_p(64, {$urandom, $urandom}, 63, 3'(m));
         run_p(64, {$urandom, $urandom}, int'($urandom_range(2, 62)), 3'(m));
      end
      run_p(16, 64'h0000_0000_0000_8001, 7, 3'b010);
      run_p(64, 64'h8000_0000_0000_0001, 9, 3'b010);
      run_p(16, {32'd0, $urandom}, 0, 3'b100);
      run_p(64, {$urandom, $urandom}, 13, 3'b110);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
